// File: rtl/mask_centroid_pkg.sv
// Shared widths and FSM encoding for the mask centroid block.
package mask_centroid_pkg;
   localparam int X_WIDTH        = 11;
   localparam int Y_WIDTH        = 10;
   localparam int CNT_WIDTH      = 20;
   localparam int SUM_W          = X_WIDTH + CNT_WIDTH;
   localparam int SUMY_W         = Y_WIDTH + CNT_WIDTH;
   localparam int DEF_MIN_PIXELS = 64;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIVIDE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

// File: rtl/mask_centroid_if.sv
// Pixel-mask input stream and centroid report bundle.
interface mask_centroid_if;
   import mask_centroid_pkg::*;

   logic                 pixel_valid;
   logic [7:0]           color;
   logic [X_WIDTH-1:0]   x;
   logic [Y_WIDTH-1:0]   y;
   logic                 frame_end;

   logic [X_WIDTH-1:0]   centroid_x;
   logic [Y_WIDTH-1:0]   centroid_y;
   logic [CNT_WIDTH-1:0] pixel_count;
   logic                 found;
   logic                 centroid_valid;
   logic                 overrun;

   modport master (
      output pixel_valid, color, x, y, frame_end,
      input  centroid_x, centroid_y, pixel_count, found, centroid_valid, overrun
   );

   modport slave (
      input  pixel_valid, color, x, y, frame_end,
      output centroid_x, centroid_y, pixel_count, found, centroid_valid, overrun
   );
endinterface

// File: rtl/mask_centroid_serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, W cycles after start.
module mask_centroid_serial_divider #(
   parameter int W  = 31,
   parameter int QW = 11
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  dividend,
   input  logic [W-1:0]  divisor,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] quotient
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_reg;
   logic [W-1:0]  quo_reg;
   logic [W-1:0]  div_reg;
   logic [CW-1:0] cnt_reg;
   logic          busy_reg;
   logic          done_reg;

   logic [W:0]    trial_next;
   logic [W:0]    diff_next;
   logic          take_next;

   // Remainder stays below the divisor, so the borrow bit alone decides.
   always_comb begin
      trial_next = {rem_reg, quo_reg[W-1]};
      diff_next  = trial_next - {1'b0, div_reg};
      take_next  = ~diff_next[W];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         div_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            div_reg  <= divisor;
            cnt_reg  <= CW'(W);
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            rem_reg <= take_next ? diff_next[W-1:0] : trial_next[W-1:0];
            quo_reg <= {quo_reg[W-2:0], take_next};
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign quotient = quo_reg[QW-1:0];
endmodule

// File: rtl/mask_centroid.sv
// Per-frame hit accumulation of a binary mask and serial centroid computation.
module mask_centroid
   import mask_centroid_pkg::*;
#(
   parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
   input  logic            clock,
   input  logic            reset,
   mask_centroid_if.slave  bus
);
   logic [CNT_WIDTH-1:0] count_reg;
   logic [CNT_WIDTH-1:0] count_next;
   logic [SUM_W-1:0]     sum_x_reg;
   logic [SUM_W-1:0]     sum_x_next;
   logic [SUMY_W-1:0]    sum_y_reg;
   logic [SUMY_W-1:0]    sum_y_next;
   logic [CNT_WIDTH-1:0] snap_count_reg;
   state_t               state_reg;

   logic [X_WIDTH-1:0]   centroid_x_reg;
   logic [Y_WIDTH-1:0]   centroid_y_reg;
   logic [CNT_WIDTH-1:0] pixel_count_reg;
   logic                 found_reg;
   logic                 valid_reg;
   logic                 overrun_reg;

   logic                 hit_next;
   logic                 start_next;
   logic                 active_next;
   logic                 x_busy, y_busy, x_done, y_done;
   logic [X_WIDTH-1:0]   quo_x;
   logic [Y_WIDTH-1:0]   quo_y;

   // Counter saturation freezes the sums too, so the mean stays consistent.
   always_comb begin
      hit_next   = bus.pixel_valid && (bus.color != 8'd0) && !(&count_reg);
      count_next = count_reg;
      sum_x_next = sum_x_reg;
      sum_y_next = sum_y_reg;
      if (hit_next) begin
         count_next = count_reg + 1'b1;
         sum_x_next = sum_x_reg + SUM_W'(bus.x);
         sum_y_next = sum_y_reg + SUMY_W'(bus.y);
      end
   end

   assign start_next  = bus.frame_end && (state_reg == ST_IDLE);
   assign active_next = x_busy || y_busy || (state_reg != ST_IDLE);

   // Dividers load the frame totals including the frame_end pixel itself.
   mask_centroid_serial_divider #(.W(SUM_W), .QW(X_WIDTH)) u_div_x (
      .clock    (clock),
      .reset    (reset),
      .start    (start_next),
      .dividend (sum_x_next),
      .divisor  (SUM_W'(count_next)),
      .busy     (x_busy),
      .done     (x_done),
      .quotient (quo_x)
   );

   mask_centroid_serial_divider #(.W(SUM_W), .QW(Y_WIDTH)) u_div_y (
      .clock    (clock),
      .reset    (reset),
      .start    (start_next),
      .dividend (SUM_W'(sum_y_next)),
      .divisor  (SUM_W'(count_next)),
      .busy     (y_busy),
      .done     (y_done),
      .quotient (quo_y)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg       <= '0;
         sum_x_reg       <= '0;
         sum_y_reg       <= '0;
         snap_count_reg  <= '0;
         state_reg       <= ST_IDLE;
         centroid_x_reg  <= '0;
         centroid_y_reg  <= '0;
         pixel_count_reg <= '0;
         found_reg       <= 1'b0;
         valid_reg       <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         if (bus.frame_end) begin
            count_reg <= '0;
            sum_x_reg <= '0;
            sum_y_reg <= '0;
         end else begin
            count_reg <= count_next;
            sum_x_reg <= sum_x_next;
            sum_y_reg <= sum_y_next;
         end

         if (bus.frame_end && active_next) begin
            overrun_reg <= 1'b1;
         end

         valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start_next) begin
                  snap_count_reg <= count_next;
                  state_reg      <= ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               if (x_done && y_done) begin
                  // An empty frame would divide by zero; report the origin instead.
                  centroid_x_reg  <= (snap_count_reg == '0) ? '0 : quo_x;
                  centroid_y_reg  <= (snap_count_reg == '0) ? '0 : quo_y;
                  pixel_count_reg <= snap_count_reg;
                  found_reg       <= (snap_count_reg >= CNT_WIDTH'(MIN_PIXELS));
                  valid_reg       <= 1'b1;
                  state_reg       <= ST_DONE;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.centroid_x     = centroid_x_reg;
   assign bus.centroid_y     = centroid_y_reg;
   assign bus.pixel_count    = pixel_count_reg;
   assign bus.found          = found_reg;
   assign bus.centroid_valid = valid_reg;
   assign bus.overrun        = overrun_reg;
endmodule

// File: tb/tb_mask_centroid.sv
// Directed bench for mask_centroid: rectangle frames from a table plus corner sequences.
module tb_mask_centroid;
   import mask_centroid_pkg::*;

   // frame_end sampled at edge E0 -> valid seen at the falling edge after E0+SUM_W+1.
   localparam int EXP_WAIT = SUM_W + 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   mask_centroid_if bus();

   mask_centroid dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int cyc = 0;
   int pulses = 0;
   int last_fe = 0;
   int pass_cnt = 0;
   int total_cnt = 0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.centroid_valid) pulses <= pulses + 1;
   end

   typedef struct {
      int x0, y0, w, h;
      int exp_cx, exp_cy, exp_cnt, exp_found;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic drive(input bit v, input int c, input int px, input int py, input bit fe);
      @(negedge clock);
      bus.pixel_valid = v;
      bus.color       = 8'(c);
      bus.x           = X_WIDTH'(px);
      bus.y           = Y_WIDTH'(py);
      bus.frame_end   = fe;
      if (fe) last_fe = cyc;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 0, 1'b0);
   endtask

   // Waits for the next report and checks it against the expected values.
   task automatic expect_report(input string name, input int fe_ref, input int cx,
                                input int cy, input int cnt, input int fnd);
      int vcyc;
      vcyc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         if (bus.centroid_valid) begin
            vcyc = cyc;
            break;
         end
      end
      $display("report %s: cx=%0d cy=%0d cnt=%0d found=%0d wait=%0d", name,
               bus.centroid_x, bus.centroid_y, bus.pixel_count, bus.found, vcyc - fe_ref);
      check({name, "_latency"}, (vcyc < 0) ? -1 : vcyc - fe_ref, EXP_WAIT);
      check({name, "_cx"}, bus.centroid_x, cx);
      check({name, "_cy"}, bus.centroid_y, cy);
      check({name, "_cnt"}, bus.pixel_count, cnt);
      check({name, "_found"}, bus.found, fnd);
      @(negedge clock);
      check({name, "_pulse_width"}, bus.centroid_valid, 0);
   endtask

   task automatic send_rect(input int x0, input int y0, input int w, input int h);
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            drive(1'b1, ((xx + yy) % 2 == 1) ? 1 : 255, x0 + xx, y0 + yy, 1'b0);
   endtask

   task automatic check_outputs(input string name, input int cx, input int cy,
                                input int cnt, input int fnd, input int ovr);
      $display("outputs %s: cx=%0d cy=%0d cnt=%0d found=%0d overrun=%0d", name,
               bus.centroid_x, bus.centroid_y, bus.pixel_count, bus.found, bus.overrun);
      check({name, "_cx"}, bus.centroid_x, cx);
      check({name, "_cy"}, bus.centroid_y, cy);
      check({name, "_cnt"}, bus.pixel_count, cnt);
      check({name, "_found"}, bus.found, fnd);
      check({name, "_overrun"}, bus.overrun, ovr);
   endtask

   initial begin
      int fe_ref;
      int p0;

      vecs[0] = '{100,  50, 1, 1, 100,  50,  1, 0};
      vecs[1] = '{200, 300, 8, 8, 203, 303, 64, 1};
      vecs[2] = '{  0,   0, 0, 0,   0,   0,  0, 0};
      vecs[3] = '{  0, 767,63, 1,  31, 767, 63, 0};
      vecs[4] = '{2040,760, 8, 8,2043, 763, 64, 1};
      vecs[5] = '{ 10,  20, 2, 3,  10,  21,  6, 0};

      bus.pixel_valid = 1'b0;
      bus.color       = 8'd0;
      bus.x           = '0;
      bus.y           = '0;
      bus.frame_end   = 1'b0;
      repeat (3) @(negedge clock);
      check_outputs("reset", 0, 0, 0, 0, 0);
      check("reset_valid", bus.centroid_valid, 0);
      reset = 1'b1;
      repeat (2) idle();

      // Table: a rectangle of hits plus non-hit pixels, then an empty frame_end cycle.
      foreach (vecs[i]) begin
         drive(1'b1, 0, 5, 5, 1'b0);
         drive(1'b0, 255, 900, 700, 1'b0);
         send_rect(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
         drive(1'b0, 0, 0, 0, 1'b1);
         fe_ref = last_fe;
         idle();
         expect_report($sformatf("vec%0d", i), fe_ref, vecs[i].exp_cx, vecs[i].exp_cy,
                       vecs[i].exp_cnt, vecs[i].exp_found);
         repeat (3) idle();
      end

      // Pixel on the frame_end cycle ends frame N; pixel right after starts N+1.
      drive(1'b1, 255, 10, 10, 1'b0);
      drive(1'b1, 255, 20, 20, 1'b0);
      drive(1'b1, 255, 30, 30, 1'b1);
      fe_ref = last_fe;
      drive(1'b1, 7, 40, 40, 1'b0);
      idle();
      expect_report("edge_n", fe_ref, 20, 20, 3, 0);
      drive(1'b0, 0, 0, 0, 1'b1);
      fe_ref = last_fe;
      idle();
      expect_report("edge_n1", fe_ref, 40, 40, 1, 0);
      check("overrun_before", bus.overrun, 0);

      // Second frame_end 10 cycles after the first: frame dropped, overrun sticks.
      send_rect(200, 300, 8, 8);
      drive(1'b0, 0, 0, 0, 1'b1);
      fe_ref = last_fe;
      for (int i = 1; i <= 9; i++) begin
         if (i == 3) drive(1'b1, 255, 1, 1, 1'b0);
         else idle();
      end
      drive(1'b0, 0, 0, 0, 1'b1);
      idle();
      expect_report("ovr_first", fe_ref, 203, 303, 64, 1);
      check("ovr_set", bus.overrun, 1);
      p0 = pulses;
      repeat (60) idle();
      check("ovr_no_second_pulse", pulses, p0);
      check("ovr_hold_cx", bus.centroid_x, 203);
      drive(1'b1, 255, 500, 400, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b1);
      fe_ref = last_fe;
      idle();
      expect_report("ovr_after", fe_ref, 500, 400, 1, 0);
      check("ovr_sticky", bus.overrun, 1);

      // Reset during cycle 15 of a division aborts it.
      send_rect(321, 123, 2, 2);
      drive(1'b0, 0, 0, 0, 1'b1);
      repeat (15) idle();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_outputs("midreset", 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      p0 = pulses;
      repeat (50) idle();
      check("midreset_no_pulse", pulses, p0);
      drive(1'b1, 255, 7, 9, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b1);
      fe_ref = last_fe;
      idle();
      expect_report("post_reset", fe_ref, 7, 9, 1, 0);
      check("post_reset_overrun", bus.overrun, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/mask_centroid.md
Name: mask_centroid

Overview:
- Consumes the per-pixel binary mask stream produced by the HSV threshold stage (0 = background, 255 = target colour), plus its pixel coordinates.
- Accumulates hit count and coordinate sums over a frame. At end of frame, computes the target centroid with a serial divider.
- Presents the centroid to downstream tracking/display logic with a one-cycle valid strobe.

Parameters:
- X_WIDTH, 11, bits of the horizontal pixel coordinate.
- Y_WIDTH, 10, bits of the vertical pixel coordinate.
- CNT_WIDTH, 20, bits of the hit counter. Must hold max pixels per frame (1024x768).
- MIN_PIXELS, 64, minimum hit count for a frame to report found = 1.

Ports:
- clock, input, 1, system pixel clock. All logic is on the rising edge.
- reset, input, 1, asynchronous, active-low. All state clears immediately when low and releases synchronously to clock.
- pixel_valid, input, 1, the mask/coordinate inputs are meaningful this cycle.
- color, input, 8, mask value from the threshold stage. Any nonzero value is a hit.
- x, input, X_WIDTH, column of the current pixel.
- y, input, Y_WIDTH, row of the current pixel.
- frame_end, input, 1, single-cycle strobe marking the last pixel cycle of a frame.
- centroid_x, output, X_WIDTH, registered mean column of hits.
- centroid_y, output, Y_WIDTH, registered mean row of hits.
- pixel_count, output, CNT_WIDTH, hit count of the frame reported.
- found, output, 1, pixel_count >= MIN_PIXELS for the reported frame.
- centroid_valid, output, 1, one-cycle pulse when the outputs above update.
- overrun, output, 1, sticky. Set when frame_end arrives while a division is in progress.

Behaviour:
- Reset (reset low): all accumulators, snapshots, outputs and overrun go to 0. The FSM goes to IDLE.
- Accumulation runs continuously, independent of the FSM.
  - On a cycle with pixel_valid & (color != 0): count += 1, sum_x += x, sum_y += y.
  - sum_x width is X_WIDTH+CNT_WIDTH (31). sum_y width is Y_WIDTH+CNT_WIDTH (30).
  - The counter saturates at all-ones and the sums stop growing. There is no wrap.
- frame_end cycle:
  - The pixel on that same cycle belongs to the ending frame and is included in the snapshot.
  - Snapshot registers load the final count/sum_x/sum_y.
  - The live accumulators clear to 0 on the same edge. Pixels on the next cycle start the new frame.
- FSM states: IDLE -> DIVIDE -> DONE -> IDLE.
  - IDLE: on frame_end, load the snapshot and go to DIVIDE. The iteration counter is set to SUM_W = X_WIDTH+CNT_WIDTH.
  - DIVIDE: one restoring-division bit per cycle, x and y dividers in lockstep. sum_y is zero-extended to SUM_W. After SUM_W cycles, go to DONE.
  - DONE: register the outputs, pulse centroid_valid for exactly one cycle, return to IDLE.
- Latency: frame_end sampled at edge E0 gives centroid_valid high during the cycle after edge E0+SUM_W+1, i.e. 32 cycles later with defaults. The latency is fixed and independent of the data.
- Quotients are truncated (floor). The quotient is guaranteed to fit, since mean <= max coordinate. Take the low X_WIDTH/Y_WIDTH bits.
- count == 0: the divider is bypassed. Results are centroid_x = centroid_y = 0, found = 0. Latency is unchanged.
- count < MIN_PIXELS (and nonzero): the division still runs and the centroid is reported, but found = 0.
- frame_end while in DIVIDE or DONE:
  - The in-progress division completes undisturbed.
  - The live accumulators still clear (the frame is discarded).
  - overrun is set, and clears only on reset.
- Outputs other than centroid_valid hold their values between reports.
- reset asserted mid-division aborts the division. No centroid_valid is issued.

Decomposition:
- Shared package holds:
  - coordinate/count width constants (X_WIDTH, Y_WIDTH, CNT_WIDTH, SUM_W);
  - the FSM state encoding (IDLE, DIVIDE, DONE).
- Natural sub-module: serial_divider.
  - Parameterised dividend/divisor width; start/busy/done handshake; quotient output.
  - Instantiated twice (x and y).
- The top level holds the accumulators, snapshot, FSM and output registers.

Test Plan:
- Single hit pixel at (100, 50) on an otherwise empty frame, then frame_end -> 32 cycles later centroid_valid pulses once with centroid (100, 50), pixel_count 1, found 0.
- An 8x8 hit square with x 200..207 and y 300..307 -> centroid (203, 303), pixel_count 64, found 1. Latency is exactly 32 cycles.
- Hit pixels on the frame_end cycle and the cycle after it -> the first counts toward frame N and the second toward frame N+1. Verify pixel_count for both reports.
- Frame with no hits -> centroid (0, 0), found 0, pixel_count 0, centroid_valid still pulses after 32 cycles.
- frame_end 10 cycles after the previous frame_end -> the first result is correct, no second pulse for the dropped frame, and overrun = 1 until reset.
- reset low at cycle 15 of a division -> outputs 0 immediately, no centroid_valid. A subsequent frame reports normally.
